// File: rtl/z480_pkg.sv
// Shared Z480 core types; only the renamed-uop record is needed by the ROB.
package z480_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  pdst;
    logic [4:0]  rd;
    logic [3:0]  fu;
  } z480_uop_rn_t;

endpackage

// File: rtl/z480_rob_if.sv
// ROB-facing bundle: dispatch allocation, writeback completion, commit head.
// master = core side (dispatch/writeback/commit), slave = the ROB itself.
interface z480_rob_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
);
  logic                  flush;
  logic                  alloc_valid;
  logic                  alloc_ready;
  z480_pkg::z480_uop_rn_t alloc_uop;
  logic [IDX_W-1:0]      alloc_idx;
  logic                  cmpl_valid;
  logic [IDX_W-1:0]      cmpl_idx;
  logic                  cmpl_trap;
  logic [31:0]           cmpl_trap_cause;
  logic                  rob_head_valid;
  logic                  rob_head_done;
  z480_pkg::z480_uop_rn_t rob_head_uop;
  logic [IDX_W-1:0]      rob_head_idx;
  logic                  rob_head_has_trap;
  logic [31:0]           rob_head_trap_cause;
  logic                  rob_head_pop;
  logic [IDX_W:0]        count;
  logic                  full;
  logic                  empty;

  modport master (
    output flush, alloc_valid, alloc_uop, cmpl_valid, cmpl_idx, cmpl_trap,
           cmpl_trap_cause, rob_head_pop,
    input  alloc_ready, alloc_idx, rob_head_valid, rob_head_done, rob_head_uop,
           rob_head_idx, rob_head_has_trap, rob_head_trap_cause, count, full, empty
  );

  modport slave (
    input  flush, alloc_valid, alloc_uop, cmpl_valid, cmpl_idx, cmpl_trap,
           cmpl_trap_cause, rob_head_pop,
    output alloc_ready, alloc_idx, rob_head_valid, rob_head_done, rob_head_uop,
           rob_head_idx, rob_head_has_trap, rob_head_trap_cause, count, full, empty
  );
endinterface

// File: rtl/z480_rob.sv
// Z480 reorder buffer: in-order allocate, out-of-order complete, in-order pop.
// Optional trap/cause storage is built only when Z480_ROB_TRAP_EN is defined.
module z480_rob
  import z480_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst,
  z480_rob_if.slave rob
);

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]   head_q, tail_q;
  logic [DEPTH-1:0] valid_q, done_q;
  z480_uop_rn_t     uop_q [DEPTH];
`ifdef Z480_ROB_TRAP_EN
  logic [DEPTH-1:0] trap_q;
  logic [31:0]      cause_q [DEPTH];
`endif

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             empty, full, head_valid, head_done;
  logic             alloc_fire, cmpl_fire, pop_fire;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign empty      = (head_q == tail_q);
  assign full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign head_valid = !empty && valid_q[head_idx];
  assign head_done  = head_valid && done_q[head_idx];

  // Popped entries were done, so a same-cycle completion to them is already filtered here.
  assign alloc_fire = rob.alloc_valid && !full;
  assign cmpl_fire  = rob.cmpl_valid && valid_q[rob.cmpl_idx] && !done_q[rob.cmpl_idx];
  assign pop_fire   = rob.rob_head_pop && head_valid && head_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        uop_q[i[IDX_W-1:0]] <= '0;
`ifdef Z480_ROB_TRAP_EN
        cause_q[i[IDX_W-1:0]] <= '0;
`endif
      end
`ifdef Z480_ROB_TRAP_EN
      trap_q <= '0;
`endif
    end else if (rob.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (cmpl_fire) begin
        done_q[rob.cmpl_idx] <= 1'b1;
`ifdef Z480_ROB_TRAP_EN
        trap_q[rob.cmpl_idx]  <= rob.cmpl_trap;
        cause_q[rob.cmpl_idx] <= rob.cmpl_trap_cause;
`endif
      end
      if (pop_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        uop_q[tail_idx]   <= rob.alloc_uop;
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
`ifdef Z480_ROB_TRAP_EN
        trap_q[tail_idx]  <= 1'b0;
        cause_q[tail_idx] <= '0;
`endif
        tail_q            <= tail_q + PTR_ONE;
      end
    end
  end

  assign rob.alloc_ready    = !full;
  assign rob.alloc_idx      = tail_idx;
  assign rob.count          = tail_q - head_q;
  assign rob.full           = full;
  assign rob.empty          = empty;
  assign rob.rob_head_valid = head_valid;
  assign rob.rob_head_done  = head_done;
  assign rob.rob_head_uop   = head_valid ? uop_q[head_idx] : '0;
  assign rob.rob_head_idx   = head_idx;

`ifdef Z480_ROB_TRAP_EN
  assign rob.rob_head_has_trap   = head_valid && trap_q[head_idx];
  assign rob.rob_head_trap_cause = head_valid ? cause_q[head_idx] : '0;
`else
  logic unused_trap;
  assign unused_trap             = ^{rob.cmpl_trap, rob.cmpl_trap_cause};
  assign rob.rob_head_has_trap   = 1'b0;
  assign rob.rob_head_trap_cause = '0;
`endif

endmodule

// File: tb/tb_z480_rob.sv
// Self-checking bench for z480_rob: directed scenarios plus a randomized phase,
// all compared against a program-order queue model of the buffer.
module tb_z480_rob;
  import z480_pkg::*;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;
`ifdef Z480_ROB_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  z480_rob_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) rif ();
  z480_rob #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .rob(rif));

  typedef struct {
    z480_uop_rn_t uop;
    int           idx;
    bit           done;
    bit           trap;
    logic [31:0]  cause;
  } ent_t;

  ent_t        q[$];
  int          head_pos = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] popped_pc[$];
  int          pop_cyc[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic z480_uop_rn_t mk_uop(logic [31:0] pc);
    z480_uop_rn_t u;
    u.pc   = pc;
    u.pdst = 7'($urandom);
    u.rd   = 5'($urandom);
    u.fu   = 4'($urandom);
    return u;
  endfunction

  task automatic idle();
    rif.flush           = 1'b0;
    rif.alloc_valid     = 1'b0;
    rif.alloc_uop       = '0;
    rif.cmpl_valid      = 1'b0;
    rif.cmpl_idx        = '0;
    rif.cmpl_trap       = 1'b0;
    rif.cmpl_trap_cause = '0;
    rif.rob_head_pop    = 1'b0;
  endtask

  // Reference: entries held in program order; index is position relative to head.
  task automatic model_step();
    int  tail;
    bit  do_pop;
    ent_t e;
    if (rst || rif.flush) begin
      q.delete();
      head_pos = 0;
      return;
    end
    tail   = (head_pos + q.size()) % DEPTH;
    do_pop = rif.rob_head_pop && (q.size() > 0) && q[0].done;
    if (rif.cmpl_valid) begin
      foreach (q[i]) begin
        if (q[i].idx == int'(rif.cmpl_idx)) begin
          if (!q[i].done) begin
            q[i].done  = 1'b1;
            q[i].trap  = rif.cmpl_trap;
            q[i].cause = rif.cmpl_trap_cause;
          end
        end
      end
    end
    if (do_pop) begin
      void'(q.pop_front());
      head_pos = (head_pos + 1) % DEPTH;
    end
    if (rif.alloc_valid && (q.size() + (do_pop ? 1 : 0)) < DEPTH) begin
      e.uop   = rif.alloc_uop;
      e.idx   = tail;
      e.done  = 1'b0;
      e.trap  = 1'b0;
      e.cause = '0;
      q.push_back(e);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [63:0] ex_done, ex_uop, ex_trap, ex_cause;
    sz = q.size();
    ex_done = 0; ex_uop = 0; ex_trap = 0; ex_cause = 0;
    if (sz > 0) begin
      ex_done = 64'(q[0].done);
      ex_uop  = 64'(q[0].uop);
      if (TRAP_EN && q[0].done) begin
        ex_trap  = 64'(q[0].trap);
        ex_cause = 64'(q[0].cause);
      end
    end
    chk("count",       64'(rif.count),          64'(sz));
    chk("empty",       64'(rif.empty),          64'(sz == 0));
    chk("full",        64'(rif.full),           64'(sz == DEPTH));
    chk("alloc_ready", 64'(rif.alloc_ready),    64'(sz != DEPTH));
    chk("alloc_idx",   64'(rif.alloc_idx),      64'((head_pos + sz) % DEPTH));
    chk("head_valid",  64'(rif.rob_head_valid), 64'(sz > 0));
    chk("head_done",   64'(rif.rob_head_done),  ex_done);
    chk("head_uop",    64'(rif.rob_head_uop),   ex_uop);
    chk("head_idx",    64'(rif.rob_head_idx),   64'(head_pos));
    chk("head_trap",   64'(rif.rob_head_has_trap),   ex_trap);
    chk("head_cause",  64'(rif.rob_head_trap_cause), ex_cause);
  endtask

  // Inputs are already driven; sample mid-cycle, advance the model, check after the edge.
  task automatic step();
    @(negedge clk);
    if (!rst && !rif.flush && rif.rob_head_pop && rif.rob_head_valid && rif.rob_head_done) begin
      popped_pc.push_back(rif.rob_head_uop.pc);
      pop_cyc.push_back(cyc);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    idle();
    rst = 1'b1;
    // Inputs during reset must be ignored.
    rif.alloc_valid  = 1'b1;
    rif.alloc_uop    = mk_uop(32'hdead_0000);
    rif.rob_head_pop = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle();
    chk("rst_empty",      64'(rif.empty),          64'd1);
    chk("rst_ready",      64'(rif.alloc_ready),    64'd1);
    chk("rst_alloc_idx",  64'(rif.alloc_idx),      64'd0);
    chk("rst_count",      64'(rif.count),          64'd0);
    chk("rst_head_valid", 64'(rif.rob_head_valid), 64'd0);

    // In-order retire of out-of-order completions, pop held high throughout.
    rif.rob_head_pop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_uop   = mk_uop(32'h100 + 32'(4 * k));
      step();
    end
    rif.alloc_valid = 1'b0;
    rif.cmpl_valid  = 1'b1;
    rif.cmpl_idx    = 6'd2;
    step();
    rif.cmpl_idx    = 6'd0;
    c0 = cyc;
    step();
    rif.cmpl_idx    = 6'd1;
    step();
    rif.cmpl_valid  = 1'b0;
    for (int k = 0; k < 3; k++) step();
    idle();
    chk("ooo_npops",  64'(popped_pc.size()), 64'd3);
    chk("ooo_pop0",   64'(popped_pc.size() > 0 ? popped_pc[0] : 32'hffff_ffff), 64'h100);
    chk("ooo_pop1",   64'(popped_pc.size() > 1 ? popped_pc[1] : 32'hffff_ffff), 64'h104);
    chk("ooo_pop2",   64'(popped_pc.size() > 2 ? popped_pc[2] : 32'hffff_ffff), 64'h108);
    chk("ooo_pop_at", 64'(pop_cyc.size() > 0 ? pop_cyc[0] : -1), 64'(c0 + 1));
    chk("ooo_count",  64'(rif.count), 64'd0);

    // Fill to full, refuse the 65th, then free one slot.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_uop   = mk_uop(32'h1000 + 32'(4 * k));
      step();
    end
    chk("fill_full",  64'(rif.full),        64'd1);
    chk("fill_ready", 64'(rif.alloc_ready), 64'd0);
    rif.alloc_uop = mk_uop(32'hbad0_0000);
    step();
    chk("fill_65th_count", 64'(rif.count), 64'd64);
    rif.alloc_valid = 1'b0;
    rif.cmpl_valid  = 1'b1;
    rif.cmpl_idx    = 6'd0;
    step();
    rif.cmpl_valid   = 1'b0;
    rif.rob_head_pop = 1'b1;
    rif.alloc_valid  = 1'b1;
    step();
    chk("free_ready",     64'(rif.alloc_ready), 64'd1);
    chk("free_alloc_idx", 64'(rif.alloc_idx),   64'd0);
    chk("free_count",     64'(rif.count),       64'd63);
    idle();

    // Randomized allocate/complete/pop traffic across many wraps.
    for (int k = 0; k < 200; k++) begin
      rif.alloc_valid = ($urandom_range(0, 1) == 1);
      rif.alloc_uop   = mk_uop($urandom);
      rif.cmpl_valid  = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        rif.cmpl_idx = 6'(q[$urandom_range(0, q.size() - 1)].idx);
      else
        rif.cmpl_idx = 6'($urandom);
      rif.cmpl_trap       = ($urandom_range(0, 3) == 0);
      rif.cmpl_trap_cause = $urandom;
      rif.rob_head_pop    = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();

    // Trap capture; the first completion wins.
    do_reset();
    rif.alloc_valid = 1'b1;
    rif.alloc_uop   = mk_uop(32'h200);
    step();
    rif.alloc_valid     = 1'b0;
    rif.cmpl_valid      = 1'b1;
    rif.cmpl_idx        = 6'd0;
    rif.cmpl_trap       = 1'b1;
    rif.cmpl_trap_cause = 32'h0000_0005;
    step();
    chk("trap_flag",  64'(rif.rob_head_has_trap),   TRAP_EN ? 64'd1 : 64'd0);
    chk("trap_cause", 64'(rif.rob_head_trap_cause), TRAP_EN ? 64'd5 : 64'd0);
    rif.cmpl_trap_cause = 32'h0000_0007;
    step();
    chk("trap_cause_kept", 64'(rif.rob_head_trap_cause), TRAP_EN ? 64'd5 : 64'd0);
    idle();

    // Flush beats a same-cycle allocate, complete and pop.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rif.alloc_valid = 1'b1;
      rif.alloc_uop   = mk_uop(32'h3000 + 32'(4 * k));
      step();
    end
    rif.alloc_valid = 1'b0;
    rif.cmpl_valid  = 1'b1;
    rif.cmpl_idx    = 6'd0;
    step();
    rif.flush        = 1'b1;
    rif.alloc_valid  = 1'b1;
    rif.alloc_uop    = mk_uop(32'h3fff);
    rif.cmpl_idx     = 6'd1;
    rif.rob_head_pop = 1'b1;
    step();
    chk("flush_count",      64'(rif.count),          64'd0);
    chk("flush_empty",      64'(rif.empty),          64'd1);
    chk("flush_alloc_idx",  64'(rif.alloc_idx),      64'd0);
    chk("flush_head_valid", 64'(rif.rob_head_valid), 64'd0);
    idle();
    rif.alloc_valid = 1'b1;
    rif.alloc_uop   = mk_uop(32'h300);
    step();
    idle();
    chk("post_flush_done", 64'(rif.rob_head_done),   64'd0);
    chk("post_flush_pc",   64'(rif.rob_head_uop.pc), 64'h300);
    chk("post_flush_cnt",  64'(rif.count),           64'd1);

    // Illegal strobes: completion of a free slot, pop of an undone head.
    do_reset();
    rif.cmpl_valid = 1'b1;
    rif.cmpl_idx   = 6'd0;
    step();
    idle();
    rif.alloc_valid = 1'b1;
    rif.alloc_uop   = mk_uop(32'h400);
    step();
    chk("stale_cmpl_done", 64'(rif.rob_head_done), 64'd0);
    rif.alloc_uop = mk_uop(32'h404);
    step();
    idle();
    rif.rob_head_pop = 1'b1;
    step();
    chk("early_pop_count", 64'(rif.count), 64'd2);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/z480_rob.md
# z480_rob

Reorder buffer for the Z480 P7 core. It allocates one renamed uop per cycle in program order at dispatch and records out-of-order completion and trap status from writeback. It presents the oldest entry to the commit stage and frees that entry when commit pops it. It sits between rename/dispatch and commit and is the source of every `rob_head_*` signal commit consumes.

## Interface
Parameters:
- `DEPTH`, 64: number of entries; power of two, minimum 4.
- `IDX_W`, `$clog2(DEPTH)` (6): width of the entry index.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `flush` in 1: discard all entries.
- `alloc_valid` in 1: dispatch offers a uop.
- `alloc_ready` out 1: ROB can accept; equals `!full`.
- `alloc_uop` in `z480_pkg::z480_uop_rn_t`: uop to store.
- `alloc_idx` out IDX_W: index the offered uop receives (current tail).
- `cmpl_valid` in 1: writeback completion strobe.
- `cmpl_idx` in IDX_W: completing entry.
- `cmpl_trap` in 1: completion raised a trap.
- `cmpl_trap_cause` in 32: trap cause.
- `rob_head_valid` out 1: head entry allocated.
- `rob_head_done` out 1: head entry completed.
- `rob_head_uop` out `z480_uop_rn_t`: head uop.
- `rob_head_idx` out IDX_W: head index.
- `rob_head_has_trap` out 1: head trapped.
- `rob_head_trap_cause` out 32: head trap cause.
- `rob_head_pop` in 1: commit retires the head.
- `count` out IDX_W+1: occupied entries, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation
- **Storage:** per entry, `valid`, `done`, `trap`, `cause[31:0]` and `uop`.
- **Pointers:** `head_q` and `tail_q` are IDX_W+1 bits wide; the MSB is a wrap bit. `full` is true when the indexes match and the wrap bits differ. `empty` is true when the pointers are equal.
- **Allocate:** fires when `alloc_valid && alloc_ready`.
  - Writes the uop at `tail_q[IDX_W-1:0]`.
  - Sets `valid=1`, `done=0`, `trap=0`, `cause=0`.
  - Increments `tail_q`.
- **Complete:** fires when `cmpl_valid` and entry `cmpl_idx` has `valid=1, done=0`.
  - Sets `done=1`, `trap=cmpl_trap`, and `cause=cmpl_trap_cause`.
  - A completion to an invalid or already-done entry is ignored; the first completion wins.
- **Pop:** fires when `rob_head_pop && rob_head_valid && rob_head_done`.
  - Clears `valid` at the head.
  - Increments `head_q`.
  - A pop under any other condition is ignored.
- **Head outputs:** combinational reads of the entry at `head_q`. `rob_head_idx` is `head_q[IDX_W-1:0]`. When the ROB is empty, all head outputs are 0, except `rob_head_idx`, which still shows `head_q`.
- **Flush:** clears every `valid` and `done`, sets `head_q=tail_q=0`, and clears `count`. It overrides any allocate, complete or pop in the same cycle.
- **Count:** holds at +1 for allocate only, -1 for pop only, and is unchanged when both fire.

## Timing
- **Reset values:** all state is cleared.
  - `alloc_ready=1`, `alloc_idx=0`, `count=0`, `full=0`, `empty=1`.
  - All `rob_head_*` outputs are 0.
  - While `rst` is high, all inputs are ignored.
- **Allocate to head:** an allocation into an empty ROB shows `rob_head_valid=1` on the next cycle.
- **Completion latency:** a completion in cycle N shows as `done` (and trap state) in cycle N+1, so the head can pop at N+1 at the earliest.
- **Full:** `alloc_ready` is computed from registered `full`. A pop in the same cycle does not enable an allocation; the freed slot becomes available the next cycle.
- **Empty:** allocate and pop cannot target the same entry in one cycle, because pop requires an entry that is already done.
- **Same-cycle allocate and complete:** when both target the same index, the completion is ignored because the entry is not yet valid.
- **Same-cycle pop and complete:** a completion to the head being popped is ignored because that entry is already done.
- **Wrap-around:** indexes wrap from DEPTH-1 to 0; the wrap bit toggles on each wrap.
- **Reset or flush mid-operation:** takes effect at the next edge; no pop is reported afterwards.

## Configuration
- Macro `Z480_ROB_TRAP_EN`.
  - **Defined:** `trap` and `cause` are stored per entry and driven on `rob_head_has_trap` / `rob_head_trap_cause` as described above.
  - **Undefined:** no trap or cause storage is built. `rob_head_has_trap=0` and `rob_head_trap_cause=0` at all times, and `cmpl_trap` / `cmpl_trap_cause` are ignored. All other behaviour is identical.

## Test plan
- **Reset:** drive `rst` high for 2 cycles, then low.
  - Required: `empty=1`, `alloc_ready=1`, `alloc_idx=0`, `count=0`, `rob_head_valid=0`.
- **In-order retire of out-of-order completions:**
  - Allocate uops with PCs 0x100, 0x104 and 0x108.
  - Complete idx 2, then idx 0, then idx 1, while holding `rob_head_pop=1` throughout.
  - Required: pops occur in PC order 0x100, 0x104, 0x108. The first pop happens the cycle after idx 0 completes. `count` ends at 0.
- **Fill and wrap:**
  - Allocate 64 uops. Required: `full=1`, `alloc_ready=0`, and a 65th `alloc_valid` is not accepted.
  - Complete and pop one entry. Required: `alloc_ready=1` on the next cycle and `alloc_idx=0`.
  - Run 200 allocate/complete/pop cycles. Required: indexes wrap correctly.
- **Trap capture** (`Z480_ROB_TRAP_EN` defined):
  - Complete the head with `cmpl_trap=1`, cause 0x0000_0005.
  - Required: `rob_head_has_trap=1` and `rob_head_trap_cause=5` on the next cycle.
  - A second completion to the same idx with cause 7 is ignored.
  - With the macro undefined, both trap outputs stay 0.
- **Flush priority:**
  - With 10 entries allocated, assert `flush` together with `alloc_valid`, `cmpl_valid` and `rob_head_pop` in the same cycle.
  - Required: on the next cycle `count=0`, `empty=1`, `alloc_idx=0`, `rob_head_valid=0`, and no entry is retained.
- **Illegal strobes:**
  - Pop while the head is not done: ignored, `count` unchanged.
  - Complete an unallocated idx: ignored, and a later allocation of that idx reads `done=0`.
